// File: rtl/sram_req_ctrl_if.sv
// Host request/response and SRAM-stage signal bundle for sram_req_ctrl.
// The slave modport is the controller's view; master is the host/SRAM side.
interface sram_req_ctrl_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  sram_read_o;
  logic                  sram_write_o;
  logic [ADDR_WIDTH-1:0] sram_addr_o;
  logic [DATA_WIDTH-1:0] sram_wdata_o;
  logic                  sram_rvalid_i;
  logic [DATA_WIDTH-1:0] sram_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
           sram_rvalid_i, sram_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o,
           sram_read_o, sram_write_o, sram_addr_o, sram_wdata_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
           sram_rvalid_i, sram_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o,
           sram_read_o, sram_write_o, sram_addr_o, sram_wdata_o
  );
endinterface

// File: rtl/sram_req_ctrl.sv
// Host front end for the single-port SRAM stage: credit-gated request issue,
// in-flight read tracking, fall-through response FIFO and a whole-array fill engine.
module sram_req_ctrl #(
  parameter int                    ADDR_WIDTH   = 14,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    RSP_DEPTH    = 4,
  parameter int                    READ_LATENCY = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_DATA    = '0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic init_i,
  output logic init_busy_o,
  output logic init_done_o,
  output logic err_o,
  sram_req_ctrl_if.slave bus
);

  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int DROP_W = $clog2(READ_LATENCY + 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_IDLE = 1'b1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W-1:0]      fifo_count;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
  logic [DROP_W-1:0]     drop_cnt;
  logic                  err_q;

  logic in_init, in_idle, fill_last, credit_ok, req_ready;
  logic issue_read, issue_write, fifo_full, pop;
  logic rsp_live, spurious, overflow, rsp_ret, push;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_init     = (state == ST_INIT);
  assign in_idle     = (state == ST_IDLE);
  assign fill_last   = (fill_addr == '1);
  assign credit_ok   = ({1'b0, fifo_count} + {1'b0, outstanding}) < (CNT_W + 1)'(RSP_DEPTH);
  assign req_ready   = in_idle & ~init_i & (bus.req_we_i | credit_ok);
  assign issue_read  = bus.req_valid_i & req_ready & ~bus.req_we_i;
  assign issue_write = bus.req_valid_i & req_ready & bus.req_we_i;

  assign bus.req_ready_o  = req_ready;
  assign bus.sram_read_o  = issue_read;
  assign bus.sram_write_o = in_init | issue_write;
  assign bus.sram_addr_o  = in_init ? fill_addr : bus.req_addr_i;
  assign bus.sram_wdata_o = in_init ? INIT_DATA : bus.req_wdata_i;
  assign init_busy_o      = in_init;
  assign init_done_o      = in_init & fill_last;
  assign err_o            = err_q;

  assign fifo_full       = (fifo_count == CNT_W'(RSP_DEPTH));
  assign bus.rsp_valid_o = (fifo_count != '0);
  assign bus.rsp_rdata_o = fifo_mem[rd_ptr];
  assign pop             = bus.rsp_valid_o & bus.rsp_ready_i;

  // Returns inside the post-reset window belong to reads discarded by the reset.
  assign rsp_live = bus.sram_rvalid_i & (drop_cnt == '0);
  assign spurious = rsp_live & (outstanding == '0);
  assign rsp_ret  = rsp_live & ~spurious;
  assign overflow = rsp_ret & fifo_full & ~pop;
  assign push     = rsp_ret & ~overflow;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_INIT;
      fill_addr <= '0;
    end else if (in_init) begin
      fill_addr <= fill_addr + 1'b1;
      if (fill_last) state <= ST_IDLE;
    end else if (init_i) begin
      state <= ST_INIT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding <= '0;
      drop_cnt    <= DROP_W'(READ_LATENCY);
      err_q       <= 1'b0;
    end else begin
      if (issue_read && !rsp_ret) outstanding <= outstanding + 1'b1;
      else if (!issue_read && rsp_ret) outstanding <= outstanding - 1'b1;
      if (drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
      if (spurious || overflow) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= bus.sram_rdata_i;
        wr_ptr           <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop) fifo_count <= fifo_count + 1'b1;
      else if (!push && pop) fifo_count <= fifo_count - 1'b1;
    end
  end

endmodule
